// File: rtl/ahb_arbiter_2m_pkg.sv
// Shared bus encodings, master indices and arbiter state type for the two-master AHB arbiter.
package bus_pkg;
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;

    typedef enum logic [1:0] {
        ST_PARK   = 2'b00,
        ST_OWN_M1 = 2'b01,
        ST_OWN_M2 = 2'b10
    } arb_state_e;
endpackage

// File: rtl/ahb_arbiter_2m_if.sv
// Request/grant and muxed bus-status signals exchanged between the masters, the slave side and the arbiter.
interface ahb_arbiter_2m_if;
    logic       HBUSREQ_M1;
    logic       HBUSREQ_M2;
    logic       HLOCK_M1;
    logic       HLOCK_M2;
    logic [1:0] HTRANS;
    logic       HREADY;
    logic [1:0] HRESP;
    logic       HGRANT_M1;
    logic       HGRANT_M2;
    logic       HMASTER_ADDR;
    logic       HMASTER_DATA;
    logic       HMASTLOCK;

    // Arbiter side
    modport slave (
        input  HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2, HTRANS, HREADY, HRESP,
        output HGRANT_M1, HGRANT_M2, HMASTER_ADDR, HMASTER_DATA, HMASTLOCK
    );

    // Requesting side (masters plus muxed slave status)
    modport master (
        output HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2, HTRANS, HREADY, HRESP,
        input  HGRANT_M1, HGRANT_M2, HMASTER_ADDR, HMASTER_DATA, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter_2m_beat_counter.sv
// Saturating beat counter with synchronous clear; flags when the per-grant beat limit is reached.
module beat_counter #(
    parameter int CNT_W     = 8,
    parameter int MAX_BEATS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic max_o
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BEATS);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign max_o = (cnt_q == MAX_C);
endmodule

// File: rtl/ahb_arbiter_2m.sv
// Two-master round-robin AHB arbiter with beat limit, locked sequences, RETRY/SPLIT handover and parking on M1.
module ahb_arbiter_2m
    import bus_pkg::*;
#(
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_arbiter_2m_if.slave   bus
);
    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       gnt1_q, gnt1_d;
    logic       gnt2_q, gnt2_d;
    logic       maddr_q, maddr_d;
    logic       mdata_q;
    logic       mlock_q, mlock_d;
    logic       req1_q, req2_q, lock1_q, lock2_q;
    logic       own_req, own_lock, resp_rs, beat_act, handover, cnt_max;

    // Requests and locks are registered first so every arbitration decision sees sampled values.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        own_req  = (state_q == ST_OWN_M2) ? req2_q  : req1_q;
        own_lock = (state_q == ST_OWN_M2) ? lock2_q : lock1_q;
        resp_rs  = (bus.HRESP == RESP_RETRY) || (bus.HRESP == RESP_SPLIT);
        beat_act = (bus.HTRANS == TRANS_NONSEQ) || (bus.HTRANS == TRANS_SEQ);
        handover = (state_q == ST_PARK) || !own_req || (!own_lock && (cnt_max || resp_rs));

        if (handover) begin
            if (req1_q && req2_q) begin
                state_d = (last_q == M1) ? ST_OWN_M2 : ST_OWN_M1;
            end else if (req1_q) begin
                state_d = ST_OWN_M1;
            end else if (req2_q) begin
                state_d = ST_OWN_M2;
            end else begin
                state_d = ST_PARK;
            end
        end

        if (state_d != ST_PARK) begin
            last_d = (state_d == ST_OWN_M2) ? M2 : M1;
        end

        gnt2_d  = (state_d == ST_OWN_M2);
        gnt1_d  = !gnt2_d;
        maddr_d = gnt2_d ? M2 : M1;
        case (state_d)
            ST_OWN_M1: mlock_d = lock1_q;
            ST_OWN_M2: mlock_d = lock2_q;
            default:   mlock_d = 1'b0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_PARK;
            last_q  <= M2;
            gnt1_q  <= 1'b1;
            gnt2_q  <= 1'b0;
            maddr_q <= M1;
            mdata_q <= M1;
            mlock_q <= 1'b0;
            req1_q  <= 1'b0;
            req2_q  <= 1'b0;
            lock1_q <= 1'b0;
            lock2_q <= 1'b0;
        end else begin
            req1_q  <= bus.HBUSREQ_M1;
            req2_q  <= bus.HBUSREQ_M2;
            lock1_q <= bus.HLOCK_M1;
            lock2_q <= bus.HLOCK_M2;
            if (bus.HREADY) begin
                state_q <= state_d;
                last_q  <= last_d;
                gnt1_q  <= gnt1_d;
                gnt2_q  <= gnt2_d;
                maddr_q <= maddr_d;
                mdata_q <= maddr_q;
                mlock_q <= mlock_d;
            end
        end
    end

    beat_counter #(
        .CNT_W     (CNT_W),
        .MAX_BEATS (MAX_BEATS)
    ) u_beat_counter (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .clr_i (bus.HREADY && (state_d != state_q)),
        .inc_i (bus.HREADY && beat_act),
        .max_o (cnt_max)
    );

    assign bus.HGRANT_M1    = gnt1_q;
    assign bus.HGRANT_M2    = gnt2_q;
    assign bus.HMASTER_ADDR = maddr_q;
    assign bus.HMASTER_DATA = mdata_q;
    assign bus.HMASTLOCK    = mlock_q;
endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Bench for ahb_arbiter_2m: directed scenarios plus random traffic checked against an ownership-level model.
module tb_ahb_arbiter_2m;
    localparam int MAX_BEATS = 8;

    logic HCLK;
    logic HRESETn;
    int   n_checks;
    int   n_fail;

    ahb_arbiter_2m_if bus ();

    ahb_arbiter_2m #(
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (8)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Model: owner 0 = parked, 1 = M1, 2 = M2; requests seen one edge late.
    int   owner, last, beats;
    bit   rq1_s, rq2_s, lk1_s, lk2_s;
    logic exp_g1, exp_g2, exp_addr, exp_data, exp_lock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; last = 2; beats = 0;
        rq1_s = 0; rq2_s = 0; lk1_s = 0; lk2_s = 0;
        exp_g1 = 1; exp_g2 = 0; exp_addr = 0; exp_data = 0; exp_lock = 0;
    endtask

    task automatic model_edge();
        bit rq_o, lk_o, may_switch;
        int nw;
        if (bus.HREADY) begin
            exp_data = exp_addr;
            rq_o = (owner == 1) ? rq1_s : (owner == 2) ? rq2_s : 1'b0;
            lk_o = (owner == 1) ? lk1_s : (owner == 2) ? lk2_s : 1'b0;
            may_switch = (owner == 0) || !rq_o ||
                         (!lk_o && (beats >= MAX_BEATS || bus.HRESP >= 2'd2));
            nw = owner;
            if (may_switch) begin
                if (rq1_s && rq2_s) nw = 3 - last;
                else if (rq1_s)     nw = 1;
                else if (rq2_s)     nw = 2;
                else                nw = 0;
            end
            if (nw != owner) beats = 0;
            else if (bus.HTRANS >= 2'd2 && beats < MAX_BEATS) beats++;
            if (nw != 0) last = nw;
            owner    = nw;
            exp_g2   = (owner == 2);
            exp_g1   = (owner != 2);
            exp_addr = (owner == 2);
            exp_lock = (owner == 1) ? lk1_s : (owner == 2) ? lk2_s : 1'b0;
        end
        rq1_s = bus.HBUSREQ_M1;
        rq2_s = bus.HBUSREQ_M2;
        lk1_s = bus.HLOCK_M1;
        lk2_s = bus.HLOCK_M2;
    endtask

    task automatic compare_all();
        chk("HGRANT_M1", bus.HGRANT_M1, exp_g1);
        chk("HGRANT_M2", bus.HGRANT_M2, exp_g2);
        chk("HMASTER_ADDR", bus.HMASTER_ADDR, exp_addr);
        chk("HMASTER_DATA", bus.HMASTER_DATA, exp_data);
        chk("HMASTLOCK", bus.HMASTLOCK, exp_lock);
        chk("grant_onehot", bus.HGRANT_M1 ^ bus.HGRANT_M2, 1'b1);
    endtask

    task automatic set_in(input bit r1, input bit r2, input bit l1, input bit l2,
                          input logic [1:0] tr, input bit rdy, input logic [1:0] rsp);
        bus.HBUSREQ_M1 = r1;
        bus.HBUSREQ_M2 = r2;
        bus.HLOCK_M1   = l1;
        bus.HLOCK_M2   = l2;
        bus.HTRANS     = tr;
        bus.HREADY     = rdy;
        bus.HRESP      = rsp;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        @(posedge HCLK);
        if (HRESETn) model_edge();
        #1;
        compare_all();
        @(negedge HCLK);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_g1"},   bus.HGRANT_M1, 1'b1);
        chk({tag, "_g2"},   bus.HGRANT_M2, 1'b0);
        chk({tag, "_addr"}, bus.HMASTER_ADDR, 1'b0);
        chk({tag, "_data"}, bus.HMASTER_DATA, 1'b0);
        chk({tag, "_lock"}, bus.HMASTLOCK, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        HRESETn  = 1'b0;
        model_reset();
        set_in(0, 0, 0, 0, 2'b00, 1, 2'b00);
        @(negedge HCLK);
        @(negedge HCLK);
        check_reset_values("reset");
        HRESETn = 1'b1;

        // Idle: grant stays parked on M1
        for (int i = 0; i < 5; i++) step();
        check_reset_values("park");

        // M2 alone, NONSEQ transfers
        set_in(0, 1, 0, 0, 2'b10, 1, 2'b00);
        for (int i = 0; i < 6; i++) step();
        chk("m2_alone_grant", bus.HGRANT_M2, 1'b1);
        chk("m2_alone_data", bus.HMASTER_DATA, 1'b1);

        // Both requesting continuously: ownership alternates on the beat limit
        set_in(1, 1, 0, 0, 2'b11, 1, 2'b00);
        for (int i = 0; i < 45; i++) step();

        // Park, then M1 takes a locked sequence while M2 waits past the beat limit
        set_in(0, 0, 0, 0, 2'b00, 1, 2'b00);
        for (int i = 0; i < 3; i++) step();
        set_in(1, 0, 1, 0, 2'b11, 1, 2'b00);
        for (int i = 0; i < 3; i++) step();
        set_in(1, 1, 1, 0, 2'b11, 1, 2'b00);
        for (int i = 0; i < 20; i++) step();
        chk("lock_keep_m1", bus.HGRANT_M1, 1'b1);
        chk("lock_mastlock", bus.HMASTLOCK, 1'b1);
        set_in(1, 1, 0, 0, 2'b11, 1, 2'b00);
        for (int i = 0; i < 3; i++) step();
        chk("unlock_to_m2", bus.HGRANT_M2, 1'b1);

        // M1 owns, RETRY with wait states, M2 requesting
        set_in(1, 0, 0, 0, 2'b10, 1, 2'b00);
        for (int i = 0; i < 4; i++) step();
        set_in(1, 1, 0, 0, 2'b11, 1, 2'b00);
        step();
        set_in(1, 1, 0, 0, 2'b11, 0, 2'b10);
        for (int i = 0; i < 2; i++) step();
        set_in(1, 1, 0, 0, 2'b11, 1, 2'b10);
        step();
        chk("retry_to_m2", bus.HGRANT_M2, 1'b1);
        set_in(1, 1, 0, 0, 2'b11, 1, 2'b00);
        for (int i = 0; i < 3; i++) step();

        // Asynchronous reset mid-burst while M2 owns and the slave stalls
        set_in(0, 1, 0, 0, 2'b11, 1, 2'b00);
        for (int i = 0; i < 4; i++) step();
        set_in(0, 1, 0, 0, 2'b11, 0, 2'b00);
        step();
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_rst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        set_in(0, 1, 0, 0, 2'b11, 1, 2'b00);
        step();
        chk("rerequest_edge1", bus.HGRANT_M2, 1'b0);
        step();
        chk("rerequest_edge2", bus.HGRANT_M2, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 7);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   (r < 5) ? 2'b00 : 2'(r - 4));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
